sync_fifo: RTL and testbench

//   Single-clock, show-ahead FIFO used as a command and sample queue in

---
 rtl/sync_fifo.sv | 110 +++++++++++
 tb/tb_sync_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy, empty and almost-full status.
// Define SYNC_FIFO_ERROR_FLAGS_EN to add sticky o_overflow / o_underflow outputs.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    output logic                       o_empty,
    output logic                       o_almost_full,
    input  logic                       i_write,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_read,
    output logic [WIDTH-1:0]           o_rdata,
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    output logic                       o_overflow,
    output logic                       o_underflow,
`endif
    output logic [$clog2(DEPTH+1)-1:0] o_queued
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic             push;
    logic             pop;
    logic [PW-1:0]    rd_ptr_next;
    logic [PW-1:0]    wr_ptr_next;
    logic [CW-1:0]    count_next;

    // Full/empty qualification uses the pre-edge count, so a push+pop on a
    // full FIFO accepts only the pop.
    always_comb begin
        push        = i_write && (count < FULL_COUNT);
        pop         = i_read && (count != '0);
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;
        count_next  = count;

        if (push) begin
            wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        end
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr_next;
            wr_ptr <= wr_ptr_next;
            count  <= count_next;
        end
    end

    // Storage is deliberately left out of reset; validity is tracked by count.
    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr] <= i_wdata;
        end
    end

    always_comb begin
        o_empty       = (count == '0);
        o_almost_full = (count >= AF_COUNT);
        o_queued      = count;
        o_rdata       = (count != '0) ? mem[rd_ptr] : '0;
    end

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags; only reset clears them.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (i_write && (count == FULL_COUNT) && !i_read) begin
                overflow_q <= 1'b1;
            end
            if (i_read && (count == '0)) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DEPTH=4, WIDTH=32).
// Expected values are hand-computed per vector.
module tb_sync_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             i_clock;
    logic             i_reset;
    logic             o_empty;
    logic             o_almost_full;
    logic             i_write;
    logic [WIDTH-1:0] i_wdata;
    logic             i_read;
    logic [WIDTH-1:0] o_rdata;
    logic [2:0]       o_queued;
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    logic             o_overflow;
    logic             o_underflow;
`endif

    int total_checks = 0;
    int bad_checks   = 0;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .o_empty       (o_empty),
        .o_almost_full (o_almost_full),
        .i_write       (i_write),
        .i_wdata       (i_wdata),
        .i_read        (i_read),
        .o_rdata       (o_rdata),
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow),
`endif
        .o_queued      (o_queued)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] wd, input logic rd);
        i_write = wr;
        i_wdata = wd;
        i_read  = rd;
        @(posedge i_clock);
        #1;
        i_write = 1'b0;
        i_read  = 1'b0;
    endtask

    initial begin
        i_reset = 1'b0;
        i_write = 1'b0;
        i_read  = 1'b0;
        i_wdata = '0;
        repeat (2) @(posedge i_clock);
        #3;
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;

        checkOutput("reset_empty", 32'(o_empty), 32'd1);
        checkOutput("reset_af", 32'(o_almost_full), 32'd0);
        checkOutput("reset_queued", 32'(o_queued), 32'd0);
        checkOutput("reset_rdata", o_rdata, 32'h0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hA0 + i, 1'b0);
            checkOutput($sformatf("fill_queued%0d", i), 32'(o_queued), i + 1);
            checkOutput($sformatf("fill_af%0d", i), 32'(o_almost_full), (i >= 2) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fill_rdata%0d", i), o_rdata, 32'hA0);
            checkOutput($sformatf("fill_empty%0d", i), 32'(o_empty), 32'd0);
        end

        applyStimulus(1'b1, 32'hFF, 1'b0);
        checkOutput("drop_queued", 32'(o_queued), 32'd4);
        checkOutput("drop_rdata", o_rdata, 32'hA0);
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        checkOutput("overflow_set", 32'(o_overflow), 32'd1);
`endif

        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain_rdata%0d", i), o_rdata, 32'hA0 + i);
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
        checkOutput("drain_rdata_end", o_rdata, 32'h0);
        checkOutput("drain_empty", 32'(o_empty), 32'd1);
        checkOutput("drain_queued", 32'(o_queued), 32'd0);

        applyStimulus(1'b1, 32'h10, 1'b0);
        applyStimulus(1'b1, 32'h11, 1'b0);
        checkOutput("wrap_pre_queued", 32'(o_queued), 32'd2);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("wrap_rdata%0d", i), o_rdata, 32'h10 + i);
            applyStimulus(1'b1, 32'h12 + i, 1'b1);
            checkOutput($sformatf("wrap_queued%0d", i), 32'(o_queued), 32'd2);
        end
        checkOutput("wrap_tail0", o_rdata, 32'h1A);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("wrap_tail1", o_rdata, 32'h1B);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("wrap_empty", 32'(o_empty), 32'd1);

        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("uflow_queued", 32'(o_queued), 32'd0);
        checkOutput("uflow_empty", 32'(o_empty), 32'd1);
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        checkOutput("underflow_set", 32'(o_underflow), 32'd1);
`endif

        applyStimulus(1'b1, 32'h20, 1'b1);
        checkOutput("empty_pp_queued", 32'(o_queued), 32'd1);
        checkOutput("empty_pp_rdata", o_rdata, 32'h20);
        applyStimulus(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h30 + i, 1'b0);
        checkOutput("full_pp_before", o_rdata, 32'h30);
        applyStimulus(1'b1, 32'h40, 1'b1);
        checkOutput("full_pp_queued", 32'(o_queued), 32'd3);
        checkOutput("full_pp_rdata", o_rdata, 32'h31);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("full_pp_last", o_rdata, 32'h33);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("full_pp_done", 32'(o_queued), 32'd0);
        checkOutput("full_pp_rdata0", o_rdata, 32'h0);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h60 + i, 1'b0);
        checkOutput("areset_pre", 32'(o_queued), 32'd3);
        #2;
        i_reset = 1'b0;
        #1;
        checkOutput("areset_empty", 32'(o_empty), 32'd1);
        checkOutput("areset_queued", 32'(o_queued), 32'd0);
        checkOutput("areset_rdata", o_rdata, 32'h0);
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        checkOutput("areset_oflow", 32'(o_overflow), 32'd0);
        checkOutput("areset_uflow", 32'(o_underflow), 32'd0);
`endif
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;
        applyStimulus(1'b1, 32'h55, 1'b0);
        checkOutput("post_reset_rdata", o_rdata, 32'h55);
        checkOutput("post_reset_queued", 32'(o_queued), 32'd1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
